// File: rtl/cc_register_bank_if.sv
// Purpose: bus bundle between the register bank and the datapath (read/write selects, C bus, flags, taps).
// Latency: wiring only; timing is defined by the register bank itself.
// Backpressure: none; every field is a plain level signal sampled each cycle.
interface cc_register_bank_if #(
   parameter int DATAWIDTH_BUS     = 32,
   parameter int DATAWIDTH_REG_SEL = 6
);
   logic [DATAWIDTH_REG_SEL-1:0] CC_REGISTERBANK_SelA_In;
   logic [DATAWIDTH_REG_SEL-1:0] CC_REGISTERBANK_SelB_In;
   logic [DATAWIDTH_REG_SEL-1:0] CC_REGISTERBANK_SelC_In;
   logic                         CC_REGISTERBANK_WriteC_InHigh;
   logic [DATAWIDTH_BUS-1:0]     CC_REGISTERBANK_DataBUSC_In;
   logic                         CC_REGISTERBANK_FlagsWrite_InHigh;
   logic [3:0]                   CC_REGISTERBANK_FlagsNZVC_In;
   logic [DATAWIDTH_BUS-1:0]     CC_REGISTERBANK_DataBUSA_Out;
   logic [DATAWIDTH_BUS-1:0]     CC_REGISTERBANK_DataBUSB_Out;
   logic [DATAWIDTH_BUS-1:0]     CC_REGISTERBANK_PC_Out;
   logic [DATAWIDTH_BUS-1:0]     CC_REGISTERBANK_IR_Out;
   logic [3:0]                   CC_REGISTERBANK_PSR_Out;

   // Datapath / control side: drives selects, C bus and flags, consumes read data.
   modport master (
      output CC_REGISTERBANK_SelA_In, CC_REGISTERBANK_SelB_In, CC_REGISTERBANK_SelC_In,
      output CC_REGISTERBANK_WriteC_InHigh, CC_REGISTERBANK_DataBUSC_In,
      output CC_REGISTERBANK_FlagsWrite_InHigh, CC_REGISTERBANK_FlagsNZVC_In,
      input  CC_REGISTERBANK_DataBUSA_Out, CC_REGISTERBANK_DataBUSB_Out,
      input  CC_REGISTERBANK_PC_Out, CC_REGISTERBANK_IR_Out, CC_REGISTERBANK_PSR_Out
   );

   // Register bank side.
   modport slave (
      input  CC_REGISTERBANK_SelA_In, CC_REGISTERBANK_SelB_In, CC_REGISTERBANK_SelC_In,
      input  CC_REGISTERBANK_WriteC_InHigh, CC_REGISTERBANK_DataBUSC_In,
      input  CC_REGISTERBANK_FlagsWrite_InHigh, CC_REGISTERBANK_FlagsNZVC_In,
      output CC_REGISTERBANK_DataBUSA_Out, CC_REGISTERBANK_DataBUSB_Out,
      output CC_REGISTERBANK_PC_Out, CC_REGISTERBANK_IR_Out, CC_REGISTERBANK_PSR_Out
   );
endinterface

// File: rtl/cc_register_bank.sv
// Purpose: architectural register file (r0..r31, pc, temp0..3, ir) plus NZVC status register.
// Latency: reads combinational (0 cycles, no bypass); C-bus write and flag capture take effect at the next edge.
// Backpressure: none; one write and one flag capture accepted every cycle.
module cc_register_bank #(
   parameter int DATAWIDTH_BUS     = 32,
   parameter int DATAWIDTH_REG_SEL = 6,
   parameter int NUM_REGS          = 38
) (
   input  logic               CC_REGISTERBANK_CLOCK_50,
   input  logic               CC_REGISTERBANK_RESET_InHigh,
   cc_register_bank_if.slave  regBus
);
   localparam logic [DATAWIDTH_REG_SEL-1:0] pcAddr   = DATAWIDTH_REG_SEL'(32);
   localparam logic [DATAWIDTH_REG_SEL-1:0] irAddr   = DATAWIDTH_REG_SEL'(37);
   localparam logic [DATAWIDTH_REG_SEL-1:0] lastAddr = DATAWIDTH_REG_SEL'(NUM_REGS - 1);

   logic [DATAWIDTH_BUS-1:0] regFile [NUM_REGS];
   logic [3:0]               psrReg;

   // r0 is hardwired zero and 38..63 are unmapped, so neither may be read or written.
   logic selAValid;
   logic selBValid;
   logic selCValid;

   assign selAValid = (regBus.CC_REGISTERBANK_SelA_In != '0) && (regBus.CC_REGISTERBANK_SelA_In <= lastAddr);
   assign selBValid = (regBus.CC_REGISTERBANK_SelB_In != '0) && (regBus.CC_REGISTERBANK_SelB_In <= lastAddr);
   assign selCValid = (regBus.CC_REGISTERBANK_SelC_In != '0) && (regBus.CC_REGISTERBANK_SelC_In <= lastAddr);

   // Register array and PSR update: reset wins over both the C-bus write and the flag capture.
   always_ff @(posedge CC_REGISTERBANK_CLOCK_50) begin
      if (CC_REGISTERBANK_RESET_InHigh) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regFile[i] <= '0;
         end
         psrReg <= 4'b0000;
      end else begin
         if (regBus.CC_REGISTERBANK_WriteC_InHigh && selCValid) begin
            regFile[regBus.CC_REGISTERBANK_SelC_In] <= regBus.CC_REGISTERBANK_DataBUSC_In;
         end
         if (regBus.CC_REGISTERBANK_FlagsWrite_InHigh) begin
            psrReg <= regBus.CC_REGISTERBANK_FlagsNZVC_In;
         end
      end
   end

   // Read ports come straight from the stored array, so a same-cycle write is never forwarded.
   always_comb begin
      regBus.CC_REGISTERBANK_DataBUSA_Out = '0;
      regBus.CC_REGISTERBANK_DataBUSB_Out = '0;
      if (selAValid) begin
         regBus.CC_REGISTERBANK_DataBUSA_Out = regFile[regBus.CC_REGISTERBANK_SelA_In];
      end
      if (selBValid) begin
         regBus.CC_REGISTERBANK_DataBUSB_Out = regFile[regBus.CC_REGISTERBANK_SelB_In];
      end
   end

   // Control-unit taps: pc and ir change only through the C-bus write port.
   assign regBus.CC_REGISTERBANK_PC_Out  = regFile[pcAddr];
   assign regBus.CC_REGISTERBANK_IR_Out  = regFile[irAddr];
   assign regBus.CC_REGISTERBANK_PSR_Out = psrReg;
endmodule

// File: tb/tb_cc_register_bank.sv
module tb_cc_register_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cc_register_bank_if bus ();

   cc_register_bank dut (
      .CC_REGISTERBANK_CLOCK_50     (clk),
      .CC_REGISTERBANK_RESET_InHigh (rst),
      .regBus                       (bus)
   );

   int          checkCount = 0;
   int          passCount  = 0;
   logic [31:0] expQ [$];
   logic [31:0] expVal;
   logic [31:0] model [64];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      bus.CC_REGISTERBANK_WriteC_InHigh     = 1'b0;
      bus.CC_REGISTERBANK_FlagsWrite_InHigh = 1'b0;
      bus.CC_REGISTERBANK_FlagsNZVC_In      = 4'b0000;
      bus.CC_REGISTERBANK_DataBUSC_In       = 32'h0;
      bus.CC_REGISTERBANK_SelC_In           = 6'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      setIdle();
      bus.CC_REGISTERBANK_SelA_In = 6'd0;
      bus.CC_REGISTERBANK_SelB_In = 6'd0;
      tick();
      rst = 1'b0;
      for (int a = 0; a < 64; a++) begin
         model[a] = 32'h0;
         bus.CC_REGISTERBANK_SelA_In = 6'(a);
         bus.CC_REGISTERBANK_SelB_In = 6'(63 - a);
         #1;
         expQ.push_back(32'h0);
         expQ.push_back(32'h0);
         expVal = expQ.pop_front();
         checkCount++;
         if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
            $display("FAIL reset_readA addr=%0d got=%h want=%h", a, bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
         else passCount++;
         expVal = expQ.pop_front();
         checkCount++;
         if (bus.CC_REGISTERBANK_DataBUSB_Out !== expVal)
            $display("FAIL reset_readB addr=%0d got=%h want=%h", 63 - a, bus.CC_REGISTERBANK_DataBUSB_Out, expVal);
         else passCount++;
      end
      expQ.push_back(32'h0);
      expQ.push_back(32'h0);
      expQ.push_back(32'h0);
      expVal = expQ.pop_front();
      checkCount++;
      if ({28'h0, bus.CC_REGISTERBANK_PSR_Out} !== expVal)
         $display("FAIL reset_psr got=%b want=%b", bus.CC_REGISTERBANK_PSR_Out, expVal[3:0]);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_PC_Out !== expVal)
         $display("FAIL reset_pc got=%h want=%h", bus.CC_REGISTERBANK_PC_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_IR_Out !== expVal)
         $display("FAIL reset_ir got=%h want=%h", bus.CC_REGISTERBANK_IR_Out, expVal);
      else passCount++;
   endtask

   task automatic test_write_read();
      bus.CC_REGISTERBANK_SelA_In       = 6'd5;
      bus.CC_REGISTERBANK_SelB_In       = 6'd5;
      bus.CC_REGISTERBANK_SelC_In       = 6'd5;
      bus.CC_REGISTERBANK_DataBUSC_In   = 32'hDEADBEEF;
      bus.CC_REGISTERBANK_WriteC_InHigh = 1'b1;
      #1;
      // Before the edge: old value (no bypass) on both ports.
      expQ.push_back(32'h0);
      expQ.push_back(32'h0);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
         $display("FAIL wr_pre_A got=%h want=%h", bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSB_Out !== expVal)
         $display("FAIL wr_pre_B got=%h want=%h", bus.CC_REGISTERBANK_DataBUSB_Out, expVal);
      else passCount++;
      tick();
      setIdle();
      expQ.push_back(32'hDEADBEEF);
      expQ.push_back(32'hDEADBEEF);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
         $display("FAIL wr_post_A got=%h want=%h", bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSB_Out !== expVal)
         $display("FAIL wr_post_B got=%h want=%h", bus.CC_REGISTERBANK_DataBUSB_Out, expVal);
      else passCount++;
   endtask

   task automatic test_r0_and_unmapped();
      logic [5:0] spotSel [5];
      logic [31:0] spotExp [5];
      spotSel = '{6'd0, 6'd40, 6'd1, 6'd5, 6'd63};
      spotExp = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
      bus.CC_REGISTERBANK_SelC_In       = 6'd0;
      bus.CC_REGISTERBANK_DataBUSC_In   = 32'h12345678;
      bus.CC_REGISTERBANK_WriteC_InHigh = 1'b1;
      tick();
      bus.CC_REGISTERBANK_SelC_In = 6'd40;
      tick();
      setIdle();
      for (int i = 0; i < 5; i++) begin
         bus.CC_REGISTERBANK_SelA_In = spotSel[i];
         #1;
         expQ.push_back(spotExp[i]);
         expVal = expQ.pop_front();
         checkCount++;
         if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
            $display("FAIL discard_read sel=%0d got=%h want=%h", spotSel[i], bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
         else passCount++;
      end
      expQ.push_back(32'h0);
      expQ.push_back(32'h0);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_PC_Out !== expVal)
         $display("FAIL discard_pc got=%h want=%h", bus.CC_REGISTERBANK_PC_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_IR_Out !== expVal)
         $display("FAIL discard_ir got=%h want=%h", bus.CC_REGISTERBANK_IR_Out, expVal);
      else passCount++;
   endtask

   task automatic test_pc_ir();
      bus.CC_REGISTERBANK_SelC_In       = 6'd32;
      bus.CC_REGISTERBANK_DataBUSC_In   = 32'h00000800;
      bus.CC_REGISTERBANK_WriteC_InHigh = 1'b1;
      tick();
      bus.CC_REGISTERBANK_SelC_In     = 6'd37;
      bus.CC_REGISTERBANK_DataBUSC_In = 32'h8A000000;
      tick();
      setIdle();
      expQ.push_back(32'h00000800);
      expQ.push_back(32'h8A000000);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_PC_Out !== expVal)
         $display("FAIL pc_load got=%h want=%h", bus.CC_REGISTERBANK_PC_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_IR_Out !== expVal)
         $display("FAIL ir_load got=%h want=%h", bus.CC_REGISTERBANK_IR_Out, expVal);
      else passCount++;
      // INCPC-style update with pc read on A in the same cycle.
      bus.CC_REGISTERBANK_SelA_In       = 6'd32;
      bus.CC_REGISTERBANK_SelC_In       = 6'd32;
      bus.CC_REGISTERBANK_DataBUSC_In   = 32'h00000804;
      bus.CC_REGISTERBANK_WriteC_InHigh = 1'b1;
      #1;
      expQ.push_back(32'h00000800);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
         $display("FAIL pc_same_cycle_read got=%h want=%h", bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
      else passCount++;
      tick();
      setIdle();
      expQ.push_back(32'h00000804);
      expQ.push_back(32'h00000804);
      expQ.push_back(32'h8A000000);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_PC_Out !== expVal)
         $display("FAIL pc_incr got=%h want=%h", bus.CC_REGISTERBANK_PC_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
         $display("FAIL pc_incr_readA got=%h want=%h", bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_IR_Out !== expVal)
         $display("FAIL ir_hold got=%h want=%h", bus.CC_REGISTERBANK_IR_Out, expVal);
      else passCount++;
   endtask

   task automatic test_flags();
      bus.CC_REGISTERBANK_FlagsNZVC_In      = 4'b1010;
      bus.CC_REGISTERBANK_FlagsWrite_InHigh = 1'b1;
      tick();
      expQ.push_back(32'hA);
      expVal = expQ.pop_front();
      checkCount++;
      if ({28'h0, bus.CC_REGISTERBANK_PSR_Out} !== expVal)
         $display("FAIL psr_capture got=%b want=%b", bus.CC_REGISTERBANK_PSR_Out, expVal[3:0]);
      else passCount++;
      bus.CC_REGISTERBANK_FlagsNZVC_In      = 4'b0101;
      bus.CC_REGISTERBANK_FlagsWrite_InHigh = 1'b0;
      tick();
      expQ.push_back(32'hA);
      expVal = expQ.pop_front();
      checkCount++;
      if ({28'h0, bus.CC_REGISTERBANK_PSR_Out} !== expVal)
         $display("FAIL psr_hold got=%b want=%b", bus.CC_REGISTERBANK_PSR_Out, expVal[3:0]);
      else passCount++;
      // Flag capture and C-bus write in the same cycle.
      bus.CC_REGISTERBANK_FlagsNZVC_In      = 4'b0110;
      bus.CC_REGISTERBANK_FlagsWrite_InHigh = 1'b1;
      bus.CC_REGISTERBANK_SelC_In           = 6'd9;
      bus.CC_REGISTERBANK_DataBUSC_In       = 32'hCAFEF00D;
      bus.CC_REGISTERBANK_WriteC_InHigh     = 1'b1;
      bus.CC_REGISTERBANK_SelB_In           = 6'd9;
      tick();
      setIdle();
      expQ.push_back(32'h6);
      expQ.push_back(32'hCAFEF00D);
      expVal = expQ.pop_front();
      checkCount++;
      if ({28'h0, bus.CC_REGISTERBANK_PSR_Out} !== expVal)
         $display("FAIL psr_with_write got=%b want=%b", bus.CC_REGISTERBANK_PSR_Out, expVal[3:0]);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSB_Out !== expVal)
         $display("FAIL write_with_psr got=%h want=%h", bus.CC_REGISTERBANK_DataBUSB_Out, expVal);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      // Every address written on consecutive edges; model keeps only r1..ir.
      for (int a = 0; a < 64; a++) begin
         d = $urandom;
         bus.CC_REGISTERBANK_SelC_In       = 6'(a);
         bus.CC_REGISTERBANK_DataBUSC_In   = d;
         bus.CC_REGISTERBANK_WriteC_InHigh = 1'b1;
         if (a != 0 && a < 38) model[a] = d;
         tick();
      end
      setIdle();
      for (int a = 0; a < 64; a++) begin
         bus.CC_REGISTERBANK_SelA_In = 6'(a);
         bus.CC_REGISTERBANK_SelB_In = 6'((a + 17) % 64);
         #1;
         expQ.push_back(model[a]);
         expQ.push_back(model[(a + 17) % 64]);
         expVal = expQ.pop_front();
         checkCount++;
         if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
            $display("FAIL b2b_readA addr=%0d got=%h want=%h", a, bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
         else passCount++;
         expVal = expQ.pop_front();
         checkCount++;
         if (bus.CC_REGISTERBANK_DataBUSB_Out !== expVal)
            $display("FAIL b2b_readB addr=%0d got=%h want=%h", (a + 17) % 64, bus.CC_REGISTERBANK_DataBUSB_Out, expVal);
         else passCount++;
      end
      expQ.push_back(model[32]);
      expQ.push_back(model[37]);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_PC_Out !== expVal)
         $display("FAIL b2b_pc got=%h want=%h", bus.CC_REGISTERBANK_PC_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_IR_Out !== expVal)
         $display("FAIL b2b_ir got=%h want=%h", bus.CC_REGISTERBANK_IR_Out, expVal);
      else passCount++;
   endtask

   task automatic test_reset_priority();
      bus.CC_REGISTERBANK_SelA_In           = 6'd7;
      rst                                   = 1'b1;
      bus.CC_REGISTERBANK_SelC_In           = 6'd7;
      bus.CC_REGISTERBANK_DataBUSC_In       = 32'hFFFFFFFF;
      bus.CC_REGISTERBANK_WriteC_InHigh     = 1'b1;
      bus.CC_REGISTERBANK_FlagsNZVC_In      = 4'b1111;
      bus.CC_REGISTERBANK_FlagsWrite_InHigh = 1'b1;
      #1;
      // Until the edge, outputs still show the pre-reset state.
      expQ.push_back(model[7]);
      expQ.push_back(32'h6);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
         $display("FAIL rst_pre_r7 got=%h want=%h", bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if ({28'h0, bus.CC_REGISTERBANK_PSR_Out} !== expVal)
         $display("FAIL rst_pre_psr got=%b want=%b", bus.CC_REGISTERBANK_PSR_Out, expVal[3:0]);
      else passCount++;
      tick();
      rst = 1'b0;
      setIdle();
      expQ.push_back(32'h0);
      expVal = expQ.pop_front();
      checkCount++;
      if ({28'h0, bus.CC_REGISTERBANK_PSR_Out} !== expVal)
         $display("FAIL rst_psr got=%b want=%b", bus.CC_REGISTERBANK_PSR_Out, expVal[3:0]);
      else passCount++;
      expQ.push_back(32'h0);
      expQ.push_back(32'h0);
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_PC_Out !== expVal)
         $display("FAIL rst_pc got=%h want=%h", bus.CC_REGISTERBANK_PC_Out, expVal);
      else passCount++;
      expVal = expQ.pop_front();
      checkCount++;
      if (bus.CC_REGISTERBANK_IR_Out !== expVal)
         $display("FAIL rst_ir got=%h want=%h", bus.CC_REGISTERBANK_IR_Out, expVal);
      else passCount++;
      for (int a = 0; a < 64; a++) begin
         model[a] = 32'h0;
         bus.CC_REGISTERBANK_SelA_In = 6'(a);
         #1;
         expQ.push_back(model[a]);
         expVal = expQ.pop_front();
         checkCount++;
         if (bus.CC_REGISTERBANK_DataBUSA_Out !== expVal)
            $display("FAIL rst_clear addr=%0d got=%h want=%h", a, bus.CC_REGISTERBANK_DataBUSA_Out, expVal);
         else passCount++;
      end
   endtask

   initial begin
      setIdle();
      bus.CC_REGISTERBANK_SelA_In = 6'd0;
      bus.CC_REGISTERBANK_SelB_In = 6'd0;
      test_reset();
      test_write_read();
      test_r0_and_unmapped();
      test_pc_ir();
      test_flags();
      test_back_to_back();
      test_reset_priority();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/cc_register_bank.md
Name: cc_register_bank

Overview:
Architectural register file of the micro-datapath. It sits directly upstream of the ALU: two combinational read ports drive the ALU A and B buses, and a synchronous write port captures the ALU result (C bus) at the clock edge. It also holds the processor status flags (N, Z, V, C), captured from the ALU flag outputs on condition-code operations, and exposes PC and IR to the control unit.

Parameters:
DATAWIDTH_BUS, 32, width of every register and data bus
DATAWIDTH_REG_SEL, 6, width of the register select fields
NUM_REGS, 38, register count: r0..r31 (0..31), pc (32), temp0..temp3 (33..36), ir (37)

Ports:
CC_REGISTERBANK_CLOCK_50  in  1  single clock; all state updates on its rising edge
CC_REGISTERBANK_RESET_InHigh  in  1  synchronous, active-high reset
CC_REGISTERBANK_SelA_In  in  DATAWIDTH_REG_SEL  read address, port A
CC_REGISTERBANK_SelB_In  in  DATAWIDTH_REG_SEL  read address, port B
CC_REGISTERBANK_SelC_In  in  DATAWIDTH_REG_SEL  write address
CC_REGISTERBANK_WriteC_InHigh  in  1  write enable for the C bus
CC_REGISTERBANK_DataBUSC_In  in  DATAWIDTH_BUS  write data (ALU result)
CC_REGISTERBANK_FlagsWrite_InHigh  in  1  capture ALU flags this cycle
CC_REGISTERBANK_FlagsNZVC_In  in  4  {N,Z,V,C} from the ALU
CC_REGISTERBANK_DataBUSA_Out  out  DATAWIDTH_BUS  read data A, to ALU bus A
CC_REGISTERBANK_DataBUSB_Out  out  DATAWIDTH_BUS  read data B, to ALU bus B
CC_REGISTERBANK_PC_Out  out  DATAWIDTH_BUS  current pc register
CC_REGISTERBANK_IR_Out  out  DATAWIDTH_BUS  current ir register
CC_REGISTERBANK_PSR_Out  out  4  latched {N,Z,V,C}

Behaviour:
- One clock. Reset is synchronous and active-high: on a rising edge with RESET_InHigh=1, all 38 registers and the PSR become 0. Write and flag strobes are ignored that cycle. Until the next edge, outputs reflect the pre-reset state.
- Reads are combinational from the stored array, with no write-through bypass. A write at edge k is visible on A/B/PC/IR from edge k onward, never in the same cycle it is presented.
- r0 (address 0) always reads 0. Writes to address 0 are discarded.
- Addresses 38..63: reads return 0 and writes are discarded.
- Write: at a rising edge with WriteC_InHigh=1, register[SelC] <= DataBUSC_In. Exactly one register changes per cycle.
- SelA = SelB is legal; both ports return the same value.
- Read and write of the same address in one cycle: the read port shows the old value; the new value appears after the edge.
- PC_Out and IR_Out are direct taps of registers 32 and 37. They update only through the C-bus write port, e.g. INCPC results are written with SelC=32.
- PSR: at an edge with FlagsWrite_InHigh=1, PSR <= FlagsNZVC_In. Otherwise PSR holds. The flag write is independent of the C-bus write, and both may occur in the same cycle.
- Reset takes priority over the data write and the flag write in the same cycle.
- Latency: read 0 cycles (combinational), write 1 edge, flags 1 edge.
- No X propagation: every array entry is defined from the first reset.

Test Plan:
- Reset, then read all addresses 0..63 on A and B: every result is 0x00000000, and PSR=4'b0000.
- Write 0xDEADBEEF to r5 (SelC=5, WriteC=1) while SelA=5. Before the edge A=0; after the edge A=0xDEADBEEF. Same cycle, SelB=5: B=0xDEADBEEF after the edge.
- Write 0x12345678 to address 0, then to address 40: A with SelA=0 reads 0 and A with SelA=40 reads 0. No other register changes (spot-check r1, pc, ir still 0).
- Write 0x00000800 to 32 and 0x8A000000 to 37: PC_Out=0x00000800 and IR_Out=0x8A000000 after the edge. Then write 0x00000804 to 32: PC_Out=0x00000804 after the next edge.
- FlagsNZVC_In=4'b1010 with FlagsWrite=1: PSR=1010 after the edge. Then FlagsNZVC_In=4'b0101 with FlagsWrite=0: PSR stays 1010.
- Assert RESET together with WriteC=1 (r7 <= 0xFFFFFFFF) and FlagsWrite=1 (1111): after the edge r7=0 and PSR=0000. Registers loaded earlier (r5, pc, ir) are also 0.
